// File: rtl/sd_px_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_px_packer: packs an SD sector byte stream into 32-bit words and   |
// | paces them through a small FIFO into lcd_if's stream port. Rev 1.0   |
// +----------------------------------------------------------------------+
module sd_px_packer #(
  parameter int unsigned SECTOR_BYTES = 512,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] stream_data,
  output logic        stream_trigger,
  input  logic        stream_busy
);

  localparam int unsigned BC_W  = $clog2(SECTOR_BYTES) + 1;
  localparam int unsigned WORDS = SECTOR_BYTES / 4;
  localparam int unsigned WC_W  = $clog2(WORDS) + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [BC_W-1:0]  BYTES_C = BC_W'(SECTOR_BYTES);
  localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
  localparam logic [WC_W-1:0]  WORDS_C = WC_W'(WORDS);
  localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} in_state_t;
  typedef enum logic [1:0] {OIDLE = 2'd0, OPULSE = 2'd1, OWAIT = 2'd2} out_state_t;

  in_state_t        in_state_q,    in_state_d;
  out_state_t       out_state_q,   out_state_d;
  logic             owait_first_q, owait_first_d;
  logic [BC_W-1:0]  byte_cnt_q,    byte_cnt_d;
  logic [1:0]       lane_q,        lane_d;
  logic [23:0]      word_q,        word_d;
  logic [WC_W-1:0]  word_cnt_q,    word_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
  logic [CNT_W-1:0] count_q,       count_d;
  logic [31:0]      data_q,        data_d;
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [31:0]      mem_d [FIFO_DEPTH];

  logic fifo_full, fifo_empty, accept, push, pop;

  // Full is taken from the registered count, so a pop cannot unblock a push in the same cycle.
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign in_ready   = (in_state_q == RUN) && (byte_cnt_q < BYTES_C) &&
                      !((lane_q == 2'd3) && fifo_full);
  assign accept     = in_ready && in_valid;
  assign push       = accept && (lane_q == 2'd3);
  assign pop        = (out_state_q == OIDLE) && !fifo_empty && !stream_busy;

  always_comb begin
    in_state_d    = in_state_q;
    out_state_d   = out_state_q;
    owait_first_d = owait_first_q;
    byte_cnt_d    = byte_cnt_q;
    lane_d        = lane_q;
    word_d        = word_q;
    word_cnt_d    = word_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    data_d        = data_q;
    mem_d         = mem_q;

    case (in_state_q)
      IDLE: begin
        if (start) begin
          in_state_d = RUN;
          byte_cnt_d = '0;
          lane_d     = '0;
          word_d     = '0;
          word_cnt_d = '0;
        end
      end
      RUN: begin
        if (byte_cnt_q == BYTES_C) in_state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && (out_state_q == OIDLE) && (word_cnt_q == WORDS_C)) in_state_d = DONE;
      end
      DONE:    in_state_d = IDLE;
      default: in_state_d = IDLE;
    endcase

    if (accept) begin
      byte_cnt_d = byte_cnt_q + BC_ONE;
      lane_d     = lane_q + 2'd1;
      case (lane_q)
        2'd0:    word_d[23:16] = in_data;
        2'd1:    word_d[15:8]  = in_data;
        2'd2:    word_d[7:0]   = in_data;
        default: word_d        = word_q;
      endcase
    end

    if (push) begin
      mem_d[wr_ptr_q] = {word_q, in_data};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;

    case (out_state_q)
      OIDLE: begin
        if (pop) begin
          out_state_d = OPULSE;
          data_d      = mem_q[rd_ptr_q];
        end
      end
      OPULSE: begin
        out_state_d   = OWAIT;
        owait_first_d = 1'b1;
        word_cnt_d    = word_cnt_q + WC_ONE;
      end
      OWAIT: begin
        // lcd_if raises stream_busy one cycle after the trigger; don't trust it yet.
        if (owait_first_q)     owait_first_d = 1'b0;
        else if (!stream_busy) out_state_d   = OIDLE;
      end
      default: out_state_d = OIDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_q    <= IDLE;
      out_state_q   <= OIDLE;
      owait_first_q <= 1'b0;
      byte_cnt_q    <= '0;
      lane_q        <= '0;
      word_q        <= '0;
      word_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      data_q        <= '0;
      mem_q         <= '{default: '0};
    end else begin
      in_state_q    <= in_state_d;
      out_state_q   <= out_state_d;
      owait_first_q <= owait_first_d;
      byte_cnt_q    <= byte_cnt_d;
      lane_q        <= lane_d;
      word_q        <= word_d;
      word_cnt_q    <= word_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      data_q        <= data_d;
      mem_q         <= mem_d;
    end
  end

  assign busy           = (in_state_q != IDLE);
  assign done           = (in_state_q == DONE);
  assign stream_trigger = (out_state_q == OPULSE);
  assign stream_data    = data_q;

endmodule
`default_nettype wire
